// File: rtl/alu8_seq.sv
// Two-pass 8-bit sequencer driving a 4-bit ALU slice: low nibble, then high nibble with chained carry.
// Latency: start at edge k -> LO k..k+1, HI k+1..k+2, done/result visible k+2..k+3.
// Backpressure: start is taken in IDLE or DONE only; strobes during LO/HI are dropped (no queueing).
module alu8_seq (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic [7:0] i_opa,
    input  logic [7:0] i_opb,
    input  logic       i_cin,
    input  logic       i_acc,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result,
    output logic       o_cout,
    output logic [3:0] o_alu_a,
    output logic [3:0] o_alu_b,
    output logic       o_alu_c,
    output logic [1:0] o_alu_ctr,
    input  logic [3:0] i_alu_d,
    input  logic       i_alu_e
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_accept;

    logic [1:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cin;
    logic [3:0] r_res_lo;
    logic       r_carry;
    logic [7:0] r_result;
    logic       r_cout;

    // A new command is taken when idle or in the completion cycle, giving one command per 3 cycles.
    assign w_accept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE/DONE -> LO on accept, LO -> HI -> DONE unconditionally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_accept ? ST_LO : ST_IDLE;
            ST_LO:   w_next = ST_HI;
            ST_HI:   w_next = ST_DONE;
            ST_DONE: w_next = w_accept ? ST_LO : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode: status flags and ALU drive; ALU inputs are zero outside LO/HI.
    always_comb begin
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_alu_a   = 4'h0;
        o_alu_b   = 4'h0;
        o_alu_c   = 1'b0;
        o_alu_ctr = 2'b00;
        case (r_state)
            ST_LO: begin
                o_busy    = 1'b1;
                o_alu_a   = r_a[3:0];
                o_alu_b   = r_b[3:0];
                o_alu_c   = r_cin;
                o_alu_ctr = r_op;
            end
            ST_HI: begin
                o_busy    = 1'b1;
                o_alu_a   = r_a[7:4];
                o_alu_b   = r_b[7:4];
                o_alu_c   = r_carry;
                o_alu_ctr = r_op;
            end
            ST_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: latch the command on accept, capture the low nibble, then commit the full result.
    // With acc set, operand A is the result as it stands at the accept edge (last completed value).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= 2'b00;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_cin    <= 1'b0;
            r_res_lo <= 4'h0;
            r_carry  <= 1'b0;
            r_result <= 8'h00;
            r_cout   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= i_op;
                r_a   <= i_acc ? r_result : i_opa;
                r_b   <= i_opb;
                r_cin <= i_cin;
            end
            if (r_state == ST_LO) begin
                r_res_lo <= i_alu_d;
                r_carry  <= i_alu_e;
            end
            if (r_state == ST_HI) begin
                r_result <= {i_alu_d, r_res_lo};
                r_cout   <= i_alu_e;
            end
        end
    end

    assign o_result = r_result;
    assign o_cout   = r_cout;

endmodule

// File: tb/tb_alu8_seq.sv
// Bench for alu8_seq: stand-in adder ALU, per-cycle compare against an arithmetic model,
// plus directed commands with hand-computed results and randomized traffic with reset pulses.
module tb_alu8_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] opa = 8'h00;
    logic [7:0] opb = 8'h00;
    logic       cin = 1'b0;
    logic       acc = 1'b0;
    logic       busy, done, cout, alu_c, alu_e;
    logic [7:0] result;
    logic [3:0] alu_a, alu_b, alu_d;
    logic [1:0] alu_ctr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu8_seq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_opa(opa), .i_opb(opb), .i_cin(cin), .i_acc(acc),
        .o_busy(busy), .o_done(done), .o_result(result), .o_cout(cout),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_c(alu_c), .o_alu_ctr(alu_ctr),
        .i_alu_d(alu_d), .i_alu_e(alu_e)
    );

    // Stand-in ALU: 4-bit adder, op ignored.
    assign {alu_e, alu_d} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_t = cycles since acceptance (-1 idle); result is a plain 8-bit add with carry.
    int         m_t = -1;
    logic [7:0] m_result = 8'h00;
    logic       m_cout = 1'b0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic       m_cin = 1'b0;
    logic       m_c1 = 1'b0;
    logic [1:0] m_op = 2'b00;
    logic [8:0] m_sum = 9'h000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t      <= -1;
            m_result <= 8'h00;
            m_cout   <= 1'b0;
        end else if (m_t == 0) begin
            m_t <= 1;
        end else if (m_t == 1) begin
            m_result <= m_sum[7:0];
            m_cout   <= m_sum[8];
            m_t      <= 2;
        end else if (start) begin
            m_a   <= acc ? m_result : opa;
            m_b   <= opb;
            m_cin <= cin;
            m_op  <= op;
            m_sum <= {1'b0, (acc ? m_result : opa)} + {1'b0, opb} + {8'b0, cin};
            m_c1  <= ({1'b0, (acc ? m_result[3:0] : opa[3:0])} + {1'b0, opb[3:0]} + {4'b0, cin}) > 5'd15;
            m_t   <= 0;
        end else begin
            m_t <= -1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy", busy, (m_t >= 0));
        chk("done", done, (m_t == 2));
        chk("result", result, m_result);
        chk("cout", cout, m_cout);
        chk("alu_a", alu_a, (m_t == 0) ? m_a[3:0] : (m_t == 1) ? m_a[7:4] : 4'h0);
        chk("alu_b", alu_b, (m_t == 0) ? m_b[3:0] : (m_t == 1) ? m_b[7:4] : 4'h0);
        chk("alu_c", alu_c, (m_t == 0) ? m_cin : (m_t == 1) ? m_c1 : 1'b0);
        chk("alu_ctr", alu_ctr, (m_t == 0 || m_t == 1) ? m_op : 2'b00);
    end

    // Issue one command and check the literal result in the DONE cycle.
    task automatic run_cmd(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic ac, input logic [7:0] exp_res,
                           input logic exp_cout, input bit interfere, input bit drv_chk);
        @(negedge clk);
        #2 start = 1'b1; op = o; opa = a; opb = b; cin = c; acc = ac;
        @(negedge clk);                       // LO
        if (drv_chk) begin
            chk("lo_alu_a", alu_a, 4'hF);
            chk("lo_alu_b", alu_b, 4'h1);
            chk("lo_alu_c", alu_c, 1'b0);
            chk("lo_alu_ctr", alu_ctr, 2'b10);
        end
        #2;
        if (interfere) begin
            start = 1'b1; opa = ~a; opb = 8'h33; cin = ~c; acc = 1'b0;
        end else begin
            start = 1'b0;
        end
        @(negedge clk);                       // HI
        if (drv_chk) begin
            chk("hi_alu_a", alu_a, 4'h0);
            chk("hi_alu_b", alu_b, 4'h0);
            chk("hi_alu_c", alu_c, 1'b1);
        end
        #2 start = 1'b0; acc = 1'b0;
        @(negedge clk);                       // DONE
        chk("cmd_done", done, 1'b1);
        chk("cmd_result", result, exp_res);
        chk("cmd_cout", cout, exp_cout);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_result", result, 8'h00);
        chk("idle_busy", busy, 1'b0);

        // Carry chain, overflow, accumulate, busy blocking.
        run_cmd(2'b10, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
        run_cmd(2'b00, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_cmd(2'b00, 8'h7F, 8'h80, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_cmd(2'b01, 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        run_cmd(2'b01, 8'hAA, 8'h10, 1'b0, 1'b1, 8'h18, 1'b0, 1'b0, 1'b0);
        run_cmd(2'b11, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("after_block_busy", busy, 1'b0);

        // Abort during HI, then a command right after release.
        @(negedge clk);
        #2 start = 1'b1; opa = 8'h11; opb = 8'h22; cin = 1'b0; acc = 1'b0;
        @(negedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 8'h00);
        chk("abort_busy", busy, 1'b0);
        #2 rst_n = 1'b1; start = 1'b1; opa = 8'h21; opb = 8'h21;
        @(negedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_abort_done", done, 1'b1);
        chk("post_abort_result", result, 8'h42);

        // Randomized traffic, including back-to-back starts and occasional resets.
        repeat (600) begin
            @(negedge clk);
            #2;
            start = 1'($urandom_range(0, 1));
            op    = 2'($urandom_range(0, 3));
            opa   = 8'($urandom_range(0, 255));
            opb   = 8'($urandom_range(0, 255));
            cin   = 1'($urandom_range(0, 1));
            acc   = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        #2 start = 1'b0; rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
